// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI mode-0 master.
package spi_pkg;
   localparam int SPI_BYTE_W  = 8;
   localparam int SPI_MIN_DIV = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      WAIT,
      HOLD,
      GAP
   } spi_mst_state_t;
endpackage

// File: rtl/spi_phase_timer.sv
// Phase divider: counts CLK_DIV cycles while run is high and pulses phase_done
// in the last cycle of each phase.
module spi_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic phase_done
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign phase_done = run && (cnt == CNT_LAST);

   // Parked at zero while not running, so every phase starts from a fresh count.
   always_ff @(posedge clk) begin
      if (rst || !run || phase_done) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first 8-bit frames, active-low SSEL held across
// multi-byte messages, received byte returned on a one-cycle rx_valid pulse.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   input  logic                  tx_last,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  SCK,
   output logic                  SSEL,
   output logic                  MOSI,
   input  logic                  MISO
);
   if (CLK_DIV < SPI_MIN_DIV) begin : g_bad_div
      $error("spi_master: CLK_DIV must be at least SPI_MIN_DIV");
   end

   spi_mst_state_t        state;
   logic [SPI_BYTE_W-1:0] shreg;
   logic [2:0]            bit_cnt;
   logic                  last_r;
   logic                  run;
   logic                  phase_done;
   logic                  accept;

   assign tx_ready = (state == IDLE) || (state == WAIT);
   assign busy     = (state != IDLE);
   assign accept   = tx_valid && tx_ready;
   assign run      = state inside {SETUP, HIGH, LOW, HOLD, GAP};

   spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .phase_done (phase_done)
   );

   // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         SCK      <= 1'b0;
         SSEL     <= 1'b1;
         MOSI     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         last_r   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               shreg   <= tx_data;
               last_r  <= tx_last;
               bit_cnt <= '0;
               SSEL    <= 1'b0;
               MOSI    <= tx_data[SPI_BYTE_W-1];
               state   <= SETUP;
            end
            SETUP, LOW: if (phase_done) begin
               // MISO enters at the LSB as the outgoing MSB leaves; MOSI keeps its own copy.
               SCK   <= 1'b1;
               shreg <= {shreg[SPI_BYTE_W-2:0], MISO};
               state <= HIGH;
            end
            HIGH: if (phase_done) begin
               SCK     <= 1'b0;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                  state    <= last_r ? HOLD : WAIT;
               end else begin
                  MOSI  <= shreg[SPI_BYTE_W-1];
                  state <= LOW;
               end
            end
            WAIT: if (accept) begin
               shreg  <= tx_data;
               last_r <= tx_last;
               MOSI   <= tx_data[SPI_BYTE_W-1];
               state  <= LOW;
            end
            HOLD: if (phase_done) begin
               SSEL  <= 1'b1;
               state <= GAP;
            end
            GAP: if (phase_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: timeline model of the SPI frame checked every cycle,
// a mode-0 slave stub driving MISO, and directed scenarios with literal checks.
module tb_spi_master;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       SCK;
   logic       SSEL;
   logic       MOSI;
   logic       MISO;

   logic       loopback = 1'b0;
   logic       slave_bit = 1'b0;
   logic [7:0] resp [4] = '{8'h05, 8'h00, 8'h5A, 8'hC3};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   spi_master #(.CLK_DIV(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .SCK      (SCK),
      .SSEL     (SSEL),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   always #5 clk = ~clk;

   assign MISO = loopback ? MOSI : slave_bit;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave stub: mode 0, next bit presented after each SCK fall, restarts when SSEL is high.
   int   s_cnt = 0;
   logic s_prev_sck = 1'b0;
   always @(negedge clk) begin
      if (SSEL === 1'b1) s_cnt = 0;
      else if (s_prev_sck === 1'b1 && SCK === 1'b0) s_cnt++;
      s_prev_sck = SCK;
      slave_bit  = resp[(s_cnt / 8) % 4][7 - (s_cnt % 8)];
   end

   // Timeline model: each byte is described by its accept edge and the frame formulas.
   logic       m_on = 1'b0;
   logic       m_have = 1'b0;
   logic       m_last = 1'b0;
   logic [7:0] m_byte = 8'h00;
   logic [7:0] m_rx = 8'h00;
   int         m_acc = 0;
   int         m_idx = 0;
   int         t;
   logic       e_ssel, e_sck, e_mosi, e_rxv, e_ready = 1'b0, e_busy;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_on   = 1'b1;
         m_have = 1'b0;
         m_rx   = 8'h00;
         m_idx  = 0;
      end else if (m_on) begin
         if (tx_valid && e_ready) begin
            if (!m_have || m_last) m_idx = 0;
            else                   m_idx++;
            m_have = 1'b1;
            m_acc  = cyc;
            m_byte = tx_data;
            m_last = tx_last;
         end
         if (m_have && (cyc - m_acc) == 16 * D)
            m_rx = loopback ? m_byte : resp[m_idx % 4];
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         t = cyc - m_acc;
         if (!m_have) begin
            {e_ssel, e_sck, e_mosi, e_rxv, e_ready, e_busy} = 6'b100010;
         end else if (t < 16 * D) begin
            e_ssel  = 1'b0;
            e_sck   = ((t / D) % 2) == 1;
            e_mosi  = m_byte[7 - t / (2 * D)];
            e_rxv   = 1'b0;
            e_ready = 1'b0;
            e_busy  = 1'b1;
         end else begin
            e_sck  = 1'b0;
            e_mosi = m_byte[0];
            e_rxv  = (t == 16 * D);
            if (!m_last) begin
               e_ssel  = 1'b0;
               e_ready = 1'b1;
               e_busy  = 1'b1;
            end else begin
               e_ssel  = (t >= 17 * D);
               e_ready = (t >= 18 * D);
               e_busy  = (t < 18 * D);
            end
         end
         check("outputs",
               {18'd0, SSEL, SCK, MOSI, rx_valid, tx_ready, busy, rx_data},
               {18'd0, e_ssel, e_sck, e_mosi, e_rxv, e_ready, e_busy, m_rx});
      end
   end

   // Event recorder used by the directed checks.
   int          rise_edges[$];
   int          fall_edges[$];
   logic [7:0]  rx_q[$];
   int          rx_edge = 0;
   int          ssel_rises = 0;
   int          ssel_rise_edge = 0;
   logic [15:0] mosi_sr = 16'h0;
   logic        p_sck = 1'b0;
   logic        p_ssel = 1'b1;

   always @(negedge clk) begin
      if (m_on) begin
         if (SCK && !p_sck) begin
            rise_edges.push_back(cyc);
            mosi_sr = {mosi_sr[14:0], MOSI};
         end
         if (!SCK && p_sck) fall_edges.push_back(cyc);
         if (SSEL && !p_ssel) begin
            ssel_rises++;
            ssel_rise_edge = cyc;
         end
         if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_edge = cyc;
         end
         p_sck  = SCK;
         p_ssel = SSEL;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      rise_edges.delete();
      fall_edges.delete();
      rx_q.delete();
      ssel_rises = 0;
      mosi_sr    = 16'h0;
   endtask

   // Holds tx_valid until a handshake; returns the edge that accepted the byte.
   task automatic send(input logic [7:0] d, input logic l, output int acc_edge);
      logic hs;
      acc_edge = -1;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         hs = tx_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            acc_edge = cyc;
            break;
         end
      end
      tx_valid = 1'b0;
      if (acc_edge < 0) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rx(input int target);
      for (int n = 0; n < 500 && rx_q.size() < target; n++) tick(1);
      check("rx_count", rx_q.size(), target);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 500 && busy !== 1'b0; n++) tick(1);
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int d0;
      int bad;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      tick(3);
      rst = 1'b0;

      // Reset state and a quiet idle period.
      clear_log();
      tick(20);
      @(negedge clk);
      check("idle_sck", {31'd0, SCK}, 32'd0);
      check("idle_ssel", {31'd0, SSEL}, 32'd1);
      check("idle_mosi", {31'd0, MOSI}, 32'd0);
      check("idle_ready", {31'd0, tx_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_rx_count", rx_q.size(), 32'd0);
      tick(1);

      // Single byte 0xA5 to the slave stub.
      clear_log();
      d0 = cyc;
      send(8'hA5, 1'b1, acc);
      wait_rx(1);
      check("a5_rx_edge", rx_edge - d0, 32'd65);
      check("a5_rx_data", {24'd0, rx_q[0]}, 32'h05);
      wait_idle();
      check("a5_mosi_stream", {16'd0, mosi_sr}, 32'h00A5);
      check("a5_rises", rise_edges.size(), 32'd8);
      check("a5_ssel_after_fall", ssel_rise_edge - fall_edges[7], 32'd4);
      check("a5_ready_after_ssel", cyc - ssel_rise_edge, 32'd4);

      // Two-byte message, second byte queued while the first is in flight.
      clear_log();
      send(8'h3C, 1'b0, acc);
      send(8'h01, 1'b1, acc);
      wait_idle();
      check("msg2_rx_count", rx_q.size(), 32'd2);
      check("msg2_rx0", {24'd0, rx_q[0]}, 32'h05);
      check("msg2_rx1", {24'd0, rx_q[1]}, 32'h00);
      check("msg2_rises", rise_edges.size(), 32'd16);
      check("msg2_ssel_rises", ssel_rises, 32'd1);
      check("msg2_byte_gap", rise_edges[8] - fall_edges[7], 32'd5);
      check("msg2_mosi_stream", {16'd0, mosi_sr}, 32'h3C01);

      // Loopback: MISO follows MOSI.
      loopback = 1'b1;
      clear_log();
      send(8'h81, 1'b1, acc);
      wait_idle();
      check("loop_rx", {24'd0, rx_q[0]}, 32'h81);
      loopback = 1'b0;

      // WAIT stall of 50 cycles between bytes.
      clear_log();
      send(8'h5A, 1'b0, acc);
      wait_rx(1);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (SSEL !== 1'b0 || SCK !== 1'b0) bad++;
      end
      check("stall_bus_quiet", bad, 32'd0);
      tick(1);
      send(8'hC3, 1'b1, acc);
      wait_idle();
      check("stall_rx0", {24'd0, rx_q[0]}, 32'h05);
      check("stall_rx1", {24'd0, rx_q[1]}, 32'h00);
      check("stall_mosi_stream", {16'd0, mosi_sr}, 32'h5AC3);
      check("stall_rises", rise_edges.size(), 32'd16);

      // Reset during bit 3, then a clean byte.
      clear_log();
      send(8'h96, 1'b1, acc);
      for (int n = 0; n < 200 && rise_edges.size() < 3; n++) tick(1);
      check("rst_reached_bit3", rise_edges.size(), 32'd3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ssel", {31'd0, SSEL}, 32'd1);
      check("rst_sck", {31'd0, SCK}, 32'd0);
      tick(100);
      check("rst_no_rx", rx_q.size(), 32'd0);
      clear_log();
      send(8'h42, 1'b1, acc);
      wait_idle();
      check("post_rst_rx", {24'd0, rx_q[0]}, 32'h05);
      check("post_rst_mosi", {16'd0, mosi_sr}, 32'h0042);

      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
